// File: rtl/pl_exe_div_ctrl.sv
// Iterative 32-bit restoring divider controller for the EXE stage (DIV/DIVU/REM/REMU).
// Optional macro PL_DIV_FASTPATH_EN: divide-by-zero and signed overflow finish without iterating.
module pl_exe_div_ctrl (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] r
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam int unsigned LAST = W - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [W-1:0]    dvd, dvd_nxt;
  logic [W-1:0]    dvs, dvs_nxt;
  logic [W-1:0]    rem, rem_nxt;
  logic            q_neg, q_neg_nxt;
  logic            r_neg, r_neg_nxt;
  logic            is_rem, is_rem_nxt;
  logic [W-1:0]    r_nxt;
  logic            busy_nxt, done_nxt;

  logic            sgn;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      rem_sh, diff;
  logic            q_bit;
  logic [W-1:0]    rem_step, dvd_step, q_fin, rem_fin;
  logic            special;
  logic [W-1:0]    spec_r;

  // Operand magnitudes; op[0]=0 selects the signed variants
  assign sgn   = ~op[0];
  assign a_mag = (sgn & a[W-1]) ? W'(-a) : a;
  assign b_mag = (sgn & b[W-1]) ? W'(-b) : b;

  // One restoring step: shift in the next dividend bit, keep the difference if non-negative
  assign rem_sh   = {rem, dvd[W-1]};
  assign diff     = rem_sh - {1'b0, dvs};
  assign q_bit    = ~diff[W];
  assign rem_step = q_bit ? diff[W-1:0] : rem_sh[W-1:0];
  assign dvd_step = {dvd[W-2:0], q_bit};
  assign q_fin    = q_neg ? W'(-dvd_step) : dvd_step;
  assign rem_fin  = r_neg ? W'(-rem_step) : rem_step;

`ifdef PL_DIV_FASTPATH_EN
  logic div0, ovf;
  assign div0    = (b == '0);
  assign ovf     = sgn & (a == 32'h8000_0000) & (b == 32'hFFFF_FFFF);
  assign special = div0 | ovf;
  assign spec_r  = op[1] ? (div0 ? a : '0) : (div0 ? 32'hFFFF_FFFF : 32'h8000_0000);
`else
  assign special = 1'b0;
  assign spec_r  = '0;
`endif

  // Holds the pipeline from the accepting cycle through the last iteration
  assign stall = clrn & (((state == IDLE) & start & ~cancel) | (state == RUN));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    dvd_nxt    = dvd;
    dvs_nxt    = dvs;
    rem_nxt    = rem;
    q_neg_nxt  = q_neg;
    r_neg_nxt  = r_neg;
    is_rem_nxt = is_rem;
    r_nxt      = r;
    busy_nxt   = 1'b0;
    done_nxt   = 1'b0;
    if (cancel) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            is_rem_nxt = op[1];
            dvd_nxt    = a_mag;
            dvs_nxt    = b_mag;
            rem_nxt    = '0;
            q_neg_nxt  = sgn & (a[W-1] ^ b[W-1]) & (b != '0);
            r_neg_nxt  = sgn & a[W-1];
            cnt_nxt    = '0;
            if (special) begin
              r_nxt     = spec_r;
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = RUN;
              busy_nxt  = 1'b1;
            end
          end
        end
        RUN: begin
          dvd_nxt = dvd_step;
          rem_nxt = rem_step;
          if (cnt == CW'(LAST)) begin
            r_nxt     = is_rem ? rem_fin : q_fin;
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            cnt_nxt  = cnt + CW'(1);
            busy_nxt = 1'b1;
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      rem    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      is_rem <= 1'b0;
      r      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dvd    <= dvd_nxt;
      dvs    <= dvs_nxt;
      rem    <= rem_nxt;
      q_neg  <= q_neg_nxt;
      r_neg  <= r_neg_nxt;
      is_rem <= is_rem_nxt;
      r      <= r_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pl_exe_div_ctrl.sv
// Directed bench for pl_exe_div_ctrl: vector table for results and latency, plus cancel/reset/back-to-back sequences.
module tb_pl_exe_div_ctrl;

`ifdef PL_DIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic        clk = 1'b0;
  logic        clrn, start, cancel;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        stall, busy, done;
  logic [31:0] r;

  int checks = 0;
  int failures = 0;

  pl_exe_div_ctrl dut (
    .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .stall(stall), .busy(busy), .done(done), .r(r)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          special;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op with start held until done; returns latency, stall-high and busy-high cycle counts
  task automatic run_op(input logic [1:0] t_op, input logic [31:0] t_a, input logic [31:0] t_b,
                        output int lat, output int stl, output int bsy);
    bit seen;
    @(negedge clk);
    op = t_op; a = t_a; b = t_b; start = 1'b1;
    #1;
    stl = int'(stall);
    bsy = 0;
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        a = ~t_a;
        b = t_b + 32'd3;
      end
      if (done) begin
        seen = 1'b1;
        check("stall_in_done", 32'(stall), 32'd0);
        start = 1'b0;
      end else begin
        stl += int'(stall);
        bsy += int'(busy);
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_after_done", {30'd0, busy, stall}, 32'd0);
  endtask

  int lat, stl, bsy, exp_lat, ndone;
  bit seen;

  initial begin
    vecs[0]  = '{DIVU, 32'd100,        32'd7,          32'd14,         1'b0};
    vecs[1]  = '{REMU, 32'd100,        32'd7,          32'd2,          1'b0};
    vecs[2]  = '{DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0};
    vecs[3]  = '{REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[5]  = '{REM,  32'd5,          32'd0,          32'd5,          1'b1};
    vecs[6]  = '{DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1};
    vecs[7]  = '{REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[8]  = '{DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0};
    vecs[9]  = '{REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0};
    vecs[10] = '{DIV,  32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFFF,  1'b1};
    vecs[11] = '{REM,  32'hFFFF_FFF8,  32'd0,          32'hFFFF_FFF8,  1'b1};
    vecs[12] = '{DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[13] = '{REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0};
    vecs[14] = '{DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0};

    clrn = 1'b0; start = 1'b1; cancel = 1'b0; op = DIVU; a = 32'd1; b = 32'd1;
    #12;
    check("reset_stall", 32'(stall), 32'd0);
    check("reset_outs", {30'd0, busy, done}, 32'd0);
    check("reset_r", r, 32'd0);
    @(negedge clk); clrn = 1'b1; start = 1'b0;

    foreach (vecs[i]) begin
      exp_lat = (vecs[i].special && FAST) ? 1 : 33;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, stl, bsy);
      check($sformatf("v%0d_r", i), r, vecs[i].exp);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_lat));
      check($sformatf("v%0d_stall_cycles", i), 32'(stl), 32'(exp_lat));
      check($sformatf("v%0d_busy_cycles", i), 32'(bsy), 32'(exp_lat - 1));
    end

    // cancel has priority over start in IDLE
    @(negedge clk); op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1; cancel = 1'b1;
    #1 check("cancel_prio_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    check("cancel_prio_idle", {30'd0, busy, done}, 32'd0);
    @(negedge clk); start = 1'b0; cancel = 1'b0;

    // cancel at RUN cycle 10
    run_op(DIVU, 32'd9, 32'd3, lat, stl, bsy);
    check("pre_cancel_r", r, 32'd3);
    @(negedge clk); op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("cancel_in_run", 32'(busy), 32'd1);
    cancel = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    cancel = 1'b0;
    check("cancel_outs", {29'd0, busy, done, stall}, 32'd0);
    check("cancel_r_kept", r, 32'd3);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      ndone += int'(done);
    end
    check("cancel_no_done", 32'(ndone), 32'd0);

    // reset at RUN cycle 5
    @(negedge clk); op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    repeat (5) @(posedge clk);
    #1 clrn = 1'b0;
    #1;
    check("midrst_outs", {29'd0, busy, done, stall}, 32'd0);
    check("midrst_r", r, 32'd0);
    @(negedge clk); clrn = 1'b1; start = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      ndone += int'(done);
    end
    check("midrst_no_done", 32'(ndone), 32'd0);
    run_op(DIVU, 32'd9, 32'd3, lat, stl, bsy);
    check("post_rst_r", r, 32'd3);
    check("post_rst_latency", 32'(lat), 32'd33);

    // back-to-back: start stays high through DONE into the following IDLE cycle
    @(negedge clk); op = DIVU; a = 32'd100; b = 32'd7; start = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
    end
    check("b2b_first_r", r, 32'd14);
    check("b2b_first_latency", 32'(lat), 32'd33);
    op = REMU;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check("b2b_idle_stall", 32'(stall), 32'd1);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("b2b_second_r", r, 32'd2);
    check("b2b_second_latency", 32'(lat), 32'd34);
    @(posedge clk); #1;
    check("b2b_end_idle", {29'd0, busy, done, stall}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
